br_flow_serializer_arb: RTL and testbench

- Packet-atomic round-robin arbiter that shares one flit serializer push port among NumFlows wide requesters.
- Sits directly upstream of the serializer push interface.
- Holds a grant from the first flit of a packet until the flit with last=1 is accepted, so the serializer always sees stable, uninterleaved push data.
- Tags each granted flit with its source flow ID so the narrow side can demux.

---
 rtl/br_flow_serializer_arb_pkg.sv | 18 +
 rtl/br_flow_serializer_arb_rr_select.sv | 39 +++
 rtl/br_flow_serializer_arb.sv | 152 +++++++++++++++
 tb/tb_br_flow_serializer_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_flow_serializer_arb_pkg.sv
// Shared types and constants for the packet-atomic flow serializer arbiter.
//   state_e          : arbiter FSM state (IDLE while choosing, LOCKED mid-packet)
//   CountWidth       : width of each per-flow completed-packet counter
//   flow_id_width()  : bits needed to name one of n flows
package br_flow_serializer_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int CountWidth = 16;

  function automatic int flow_id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/br_flow_serializer_arb_rr_select.sv
// Combinational round-robin selector.
// Picks the first asserted request at or after ptr, wrapping modulo NumFlows.
//   req    : request vector, one bit per flow
//   ptr    : flow with highest priority this cycle
//   gnt    : one-hot grant (all zero when nothing requests)
//   gnt_id : index of the granted flow (0 when nothing requests)
//   any    : at least one request present
module br_flow_serializer_arb_rr_select
  import br_flow_serializer_arb_pkg::*;
#(
  parameter int NumFlows = 2,
  localparam int FlowIdWidth = flow_id_width(NumFlows)
) (
  input  logic [NumFlows-1:0]    req,
  input  logic [FlowIdWidth-1:0] ptr,
  output logic [NumFlows-1:0]    gnt,
  output logic [FlowIdWidth-1:0] gnt_id,
  output logic                   any
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned; otherwise synthesis infers a latch.
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int off = 0; off < NumFlows; off++) begin
      idx = (int'(ptr) + off) % NumFlows;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = FlowIdWidth'(idx);
      end
    end
  end

endmodule

// File: rtl/br_flow_serializer_arb.sv
// Packet-atomic round-robin arbiter in front of a flit serializer push port.
// A flow keeps the grant from its first flit until its last=1 flit is
// accepted; the data path is purely combinational (zero latency).
// Ports:
//   push_*       : per-flow wide requesters (valid/ready, data, last,
//                  tail dont-care count, metadata), flattened by flow
//   ser_*        : single push interface toward the serializer;
//                  ser_metadata = {granted flow ID, granted metadata}
//   grant_id     : currently granted flow (meaningful when ser_valid=1)
//   locked       : a packet is in progress
//   pkt_count    : only with BR_FLOW_SERIALIZER_ARB_PKT_COUNT_EN defined;
//                  per-flow saturating 16-bit completed-packet counters
module br_flow_serializer_arb
  import br_flow_serializer_arb_pkg::*;
#(
  parameter int NumFlows      = 2,
  parameter int PushWidth     = 2,
  parameter int PopWidth      = 1,
  parameter int MetadataWidth = 1,
  localparam int SerializationRatio = PushWidth / PopWidth,
  localparam int SerFlitIdWidth = (SerializationRatio == 1) ? 1 : $clog2(SerializationRatio),
  localparam int FlowIdWidth = flow_id_width(NumFlows)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  output logic [NumFlows-1:0]                 push_ready,
  input  logic [NumFlows-1:0]                 push_valid,
  input  logic [NumFlows*PushWidth-1:0]       push_data,
  input  logic [NumFlows-1:0]                 push_last,
  input  logic [NumFlows*SerFlitIdWidth-1:0]  push_last_dont_care_count,
  input  logic [NumFlows*MetadataWidth-1:0]   push_metadata,
  input  logic                                ser_ready,
  output logic                                ser_valid,
  output logic [PushWidth-1:0]                ser_data,
  output logic                                ser_last,
  output logic [SerFlitIdWidth-1:0]           ser_last_dont_care_count,
  output logic [MetadataWidth+FlowIdWidth-1:0] ser_metadata,
  output logic [FlowIdWidth-1:0]              grant_id,
  output logic                                locked
`ifdef BR_FLOW_SERIALIZER_ARB_PKT_COUNT_EN
  ,
  output logic [NumFlows*CountWidth-1:0]      pkt_count
`endif
);

  state_e                 state;
  logic [FlowIdWidth-1:0] locked_id;
  logic [FlowIdWidth-1:0] ptr;

  logic [NumFlows-1:0]    rr_gnt;
  logic [FlowIdWidth-1:0] rr_id;
  logic                   rr_any;
  logic [FlowIdWidth-1:0] grant;
  logic [FlowIdWidth-1:0] next_ptr;
  logic                   pkt_done;

  br_flow_serializer_arb_rr_select #(
    .NumFlows(NumFlows)
  ) u_rr_select (
    .req    (push_valid),
    .ptr    (ptr),
    .gnt    (rr_gnt),
    .gnt_id (rr_id),
    .any    (rr_any)
  );

  // While locked the arbiter ignores everyone but the packet owner.
  assign grant    = (state == LOCKED) ? locked_id : rr_id;
  assign grant_id = grant;

  assign ser_valid                = push_valid[grant];
  assign ser_data                 = push_data[int'(grant)*PushWidth +: PushWidth];
  assign ser_last                 = push_last[grant];
  assign ser_last_dont_care_count =
    push_last_dont_care_count[int'(grant)*SerFlitIdWidth +: SerFlitIdWidth];
  assign ser_metadata = {grant, push_metadata[int'(grant)*MetadataWidth +: MetadataWidth]};

  assign pkt_done = ser_valid && ser_ready && ser_last;
  assign next_ptr = FlowIdWidth'((int'(grant) + 1) % NumFlows);

  always_comb begin
    for (int i = 0; i < NumFlows; i++) begin
      push_ready[i] = ser_ready && ser_valid && (grant == FlowIdWidth'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      locked    <= 1'b0;
      locked_id <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_done) begin
            // One-flit packet finished in its first cycle: stay unlocked.
            ptr <= next_ptr;
          end else if (ser_valid) begin
            // Also taken by a stalled single-flit packet, so the grant holds.
            state     <= LOCKED;
            locked    <= 1'b1;
            locked_id <= grant;
          end
        end
        LOCKED: begin
          if (pkt_done) begin
            state  <= IDLE;
            locked <= 1'b0;
            ptr    <= next_ptr;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef BR_FLOW_SERIALIZER_ARB_PKT_COUNT_EN
  logic [CountWidth-1:0] cnt_q [NumFlows];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumFlows; i++) cnt_q[i] <= '0;
    end else if (pkt_done && (cnt_q[grant] != '1)) begin
      cnt_q[grant] <= cnt_q[grant] + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NumFlows; i++) pkt_count[i*CountWidth +: CountWidth] = cnt_q[i];
  end
`endif

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    rr_any |-> $onehot(rr_gnt));
  a_locked_valid: assert property (@(posedge clk) disable iff (!rst_n)
    locked |-> push_valid[locked_id]);
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (ser_valid && !ser_ready) |=> (ser_valid && $stable(grant) && $stable(ser_data) &&
                                   $stable(ser_last) && $stable(ser_metadata) &&
                                   $stable(ser_last_dont_care_count)));
  a_dcc_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (ser_valid && !ser_last) |-> (ser_last_dont_care_count == '0));
`endif

endmodule

// File: tb/tb_br_flow_serializer_arb.sv
module tb_br_flow_serializer_arb;

  localparam int N    = 4;
  localparam int PW   = 8;
  localparam int POPW = 2;
  localparam int MW   = 3;
  localparam int SR   = PW / POPW;  // 4
  localparam int SFW  = 2;
  localparam int FW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         push_ready;
  logic [N-1:0]         push_valid;
  logic [N*PW-1:0]      push_data;
  logic [N-1:0]         push_last;
  logic [N*SFW-1:0]     push_last_dont_care_count;
  logic [N*MW-1:0]      push_metadata;
  logic                 ser_ready;
  logic                 ser_valid;
  logic [PW-1:0]        ser_data;
  logic                 ser_last;
  logic [SFW-1:0]       ser_last_dont_care_count;
  logic [MW+FW-1:0]     ser_metadata;
  logic [FW-1:0]        grant_id;
  logic                 locked;
`ifdef BR_FLOW_SERIALIZER_ARB_PKT_COUNT_EN
  logic [N*16-1:0]      pkt_count;
`endif

  always #5 clk = ~clk;

  br_flow_serializer_arb #(
    .NumFlows(N), .PushWidth(PW), .PopWidth(POPW), .MetadataWidth(MW)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .push_ready               (push_ready),
    .push_valid               (push_valid),
    .push_data                (push_data),
    .push_last                (push_last),
    .push_last_dont_care_count(push_last_dont_care_count),
    .push_metadata            (push_metadata),
    .ser_ready                (ser_ready),
    .ser_valid                (ser_valid),
    .ser_data                 (ser_data),
    .ser_last                 (ser_last),
    .ser_last_dont_care_count (ser_last_dont_care_count),
    .ser_metadata             (ser_metadata),
    .grant_id                 (grant_id),
    .locked                   (locked)
`ifdef BR_FLOW_SERIALIZER_ARB_PKT_COUNT_EN
    ,
    .pkt_count                (pkt_count)
`endif
  );

  // Upstream flows: each holds its current flit until it is accepted.
  logic           pend   [N];
  logic [PW-1:0]  f_data [N];
  logic           f_last [N];
  logic [SFW-1:0] f_dcc  [N];
  logic [MW-1:0]  f_meta [N];
  int             left   [N];
  bit             auto_gen;

  // Reference model: packet-level view of the arbiter.
  bit m_locked;
  int m_lock_id;
  int m_ptr;
  int m_cnt [N];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      push_valid[i]                     = pend[i];
      push_data[i*PW +: PW]             = f_data[i];
      push_last[i]                      = f_last[i];
      push_last_dont_care_count[i*SFW +: SFW] = f_dcc[i];
      push_metadata[i*MW +: MW]         = f_meta[i];
    end
  endtask

  task automatic set_flit(input int i, input logic last, input logic [SFW-1:0] dcc,
                          input logic [MW-1:0] meta);
    pend[i]   = 1'b1;
    f_data[i] = PW'($urandom);
    f_last[i] = last;
    f_dcc[i]  = dcc;
    f_meta[i] = meta;
  endtask

  // Next flit of flow i; starts a new 1..3 flit packet when none is open.
  task automatic new_flit(input int i);
    logic lst;
    if (left[i] == 0) left[i] = $urandom_range(1, 3);
    lst = (left[i] == 1);
    set_flit(i, lst, lst ? SFW'($urandom_range(0, SR-1)) : '0, MW'($urandom));
    left[i]--;
  endtask

  task automatic clear_flows();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; f_data[i] = '0; f_last[i] = 1'b0;
      f_dcc[i] = '0; f_meta[i] = '0; left[i] = 0;
    end
  endtask

  function automatic int exp_grant();
    if (m_locked) return m_lock_id;
    for (int k = 0; k < N; k++) begin
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One cycle: drive at negedge, check combinational outputs, then commit.
  task automatic step();
    int g;
    bit ev, acc, done;
    if (auto_gen) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 99) < 40) new_flit(i);
    end
    apply();
    #1;
    g  = exp_grant();
    ev = (g >= 0) && pend[g];
    check("ser_valid", ser_valid, ev);
    check("locked", locked, m_locked);
    for (int i = 0; i < N; i++)
      check($sformatf("push_ready%0d", i), push_ready[i], ev && ser_ready && (g == i));
    acc  = ev && ser_ready;
    done = 1'b0;
    if (ev) begin
      check("grant_id", grant_id, g);
      check("ser_data", ser_data, f_data[g]);
      check("ser_last", ser_last, f_last[g]);
      check("ser_dcc", ser_last_dont_care_count, f_dcc[g]);
      check("ser_metadata", ser_metadata, (g << MW) | int'(f_meta[g]));
      done = acc && f_last[g];
    end
    @(posedge clk);
    if (rst_n) begin
      if (ev) begin
        if (done) begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % N;
          if (m_cnt[g] < 65535) m_cnt[g]++;
        end else begin
          m_locked  = 1'b1;
          m_lock_id = g;
        end
      end
      if (acc) begin
        if (f_last[g]) pend[g] = 1'b0;
        else if (auto_gen) new_flit(g);
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_lock_id = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  initial begin
    auto_gen  = 1'b0;
    ser_ready = 1'b0;
    rst_n     = 1'b0;
    clear_flows();
    model_reset();
    apply();
    #12;
    check("reset_locked", locked, 1'b0);
    check("reset_ser_valid", ser_valid, 1'b0);
    check("reset_push_ready", push_ready, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flow0 two-flit packet against a persistent flow1: no interleave, no bubble.
    ser_ready = 1'b1;
    set_flit(0, 1'b0, 2'd0, 3'd1);
    set_flit(1, 1'b1, 2'd1, 3'd2);
    step();
    set_flit(0, 1'b1, 2'd3, 3'd1);
    step();
    step();

    // Flow1 stalled for 3 cycles; flow0 appears mid-stall and must wait.
    ser_ready = 1'b0;
    set_flit(1, 1'b1, 2'd0, 3'd6);
    step();
    set_flit(0, 1'b1, 2'd0, 3'd3);
    step();
    step();
    ser_ready = 1'b1;
    step();
    step();

    // Tail dont-care count and metadata tagging.
    set_flit(0, 1'b1, 2'd2, 3'd5);
    apply();
    #1;
    check("dcc_value", ser_last_dont_care_count, 2'd2);
    check("meta_tag", ser_metadata, {2'd0, 3'd5});
    step();

    // Reset while locked on flow2 drops the lock at once and zeroes the pointer.
    set_flit(2, 1'b0, 2'd0, 3'd4);
    step();
    check("locked_on_2", locked, 1'b1);
    set_flit(2, 1'b1, 2'd1, 3'd4);
    ser_ready = 1'b0;
    apply();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_locked", locked, 1'b0);
    model_reset();
    clear_flows();
    apply();
    @(negedge clk);
    rst_n = 1'b1;
    ser_ready = 1'b1;
    set_flit(0, 1'b1, 2'd0, 3'd1);
    set_flit(2, 1'b1, 2'd0, 3'd2);
    apply();
    #1;
    check("post_reset_grant", grant_id, 2'd0);
    step();
    step();

    // Randomized traffic against the reference model.
    clear_flows();
    auto_gen = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      ser_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    auto_gen = 1'b0;

`ifdef BR_FLOW_SERIALIZER_ARB_PKT_COUNT_EN
    // Drain open packets, then saturate flow0's counter.
    ser_ready = 1'b1;
    for (int c = 0; c < 40 && (m_locked || pend[0] || pend[1] || pend[2] || pend[3]); c++)
      step();
    clear_flows();
    set_flit(0, 1'b1, 2'd0, 3'd0);
    apply();
    repeat (70000) @(posedge clk);
    m_cnt[0] = 65535;
    @(negedge clk);
    check("pkt_count0_sat", pkt_count[15:0], 16'hFFFF);
    for (int i = 1; i < N; i++)
      check($sformatf("pkt_count%0d", i), pkt_count[i*16 +: 16], m_cnt[i]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
